// File: rtl/lj_audio_rx.sv
// lj_audio_rx: left-justified serial audio receiver, deserialises MSB-first stereo words into parallel pairs
module lj_audio_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adc_lrck,
    input  logic             adc_bck,
    input  logic             adc_data,
    output logic             sample_valid,
    output logic [WIDTH-1:0] left_data,
    output logic [WIDTH-1:0] right_data,
    output logic             frame_err
);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

    logic lrck_s, bck_s, data_s;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign lrck_s = adc_lrck;
            assign bck_s  = adc_bck;
            assign data_s = adc_data;
        end else begin : g_sync
            logic [2:0] sync_q [SYNC_STAGES];
            // bring lrck/bck/data into the clk domain as one bundle so they stay aligned
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= {adc_lrck, adc_bck, adc_data};
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign {lrck_s, bck_s, data_s} = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic             bck_d_q, lrck_prev_q, synced_q, have_left_q;
    logic             lrck_prev_d, synced_d, have_left_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] word_q, word_d, left_hold_q, left_hold_d;
    logic [WIDTH-1:0] left_data_q, left_data_d, right_data_q, right_data_d;
    logic             sample_valid_q, sample_valid_d, frame_err_q, frame_err_d;
    logic             bck_rise, boundary, finalise, pair_done;

    assign bck_rise  = bck_s & ~bck_d_q;
    assign boundary  = bck_rise & (lrck_s != lrck_prev_q);
    assign finalise  = boundary & synced_q;
    assign pair_done = finalise & lrck_prev_q & have_left_q;

    // shift in word bits left-aligned; extra bits beyond WIDTH are dropped, count saturates
    always_comb begin
        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        if (boundary) begin
            word_d    = {data_s, {(WIDTH-1){1'b0}}};
            bit_cnt_d = CW'(1);
        end else if (bck_rise) begin
            for (int i = 0; i < WIDTH; i++)
                if (bit_cnt_q < CNT_FULL && bit_cnt_q == CW'(WIDTH - 1 - i)) word_d[i] = data_s;
            if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CW'(1);
        end
    end

    // at each channel change close the previous word: park a left word, pair it with the next right word
    always_comb begin
        lrck_prev_d    = boundary ? lrck_s : lrck_prev_q;
        synced_d       = synced_q | boundary;
        left_hold_d    = (finalise && !lrck_prev_q) ? word_q : left_hold_q;
        have_left_d    = finalise ? !lrck_prev_q : have_left_q;
        sample_valid_d = pair_done;
        left_data_d    = pair_done ? left_hold_q : left_data_q;
        right_data_d   = pair_done ? word_q : right_data_q;
        frame_err_d    = finalise & (bit_cnt_q != CNT_FULL);
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bck_d_q        <= 1'b0;
            lrck_prev_q    <= 1'b0;
            synced_q       <= 1'b0;
            have_left_q    <= 1'b0;
            bit_cnt_q      <= '0;
            word_q         <= '0;
            left_hold_q    <= '0;
            left_data_q    <= '0;
            right_data_q   <= '0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            bck_d_q        <= bck_s;
            lrck_prev_q    <= lrck_prev_d;
            synced_q       <= synced_d;
            have_left_q    <= have_left_d;
            bit_cnt_q      <= bit_cnt_d;
            word_q         <= word_d;
            left_hold_q    <= left_hold_d;
            left_data_q    <= left_data_d;
            right_data_q   <= right_data_d;
            sample_valid_q <= sample_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign sample_valid = sample_valid_q;
    assign left_data    = left_data_q;
    assign right_data   = right_data_q;
    assign frame_err    = frame_err_q;
endmodule

// File: tb/tb_lj_audio_rx.sv
// tb_lj_audio_rx: table-driven and randomised check of lj_audio_rx with and without input synchronisers
module tb_lj_audio_rx;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst0 = 1'b1, rst2 = 1'b1;
    logic lrck = 1'b0, bck = 1'b0, data = 1'b0;
    logic sv0, fe0, sv2, fe2;
    logic [W-1:0] l0, r0, l2, r2;

    always #5 clk = ~clk;

    lj_audio_rx #(.WIDTH(W), .SYNC_STAGES(0)) u0 (
        .clk(clk), .rst(rst0), .adc_lrck(lrck), .adc_bck(bck), .adc_data(data),
        .sample_valid(sv0), .left_data(l0), .right_data(r0), .frame_err(fe0));

    lj_audio_rx #(.WIDTH(W), .SYNC_STAGES(2)) u2 (
        .clk(clk), .rst(rst2), .adc_lrck(lrck), .adc_bck(bck), .adc_data(data),
        .sample_valid(sv2), .left_data(l2), .right_data(r2), .frame_err(fe2));

    typedef struct {
        logic [31:0] lv; int ln;
        logic [31:0] rv; int rn;
        int half;
        logic [15:0] el, er;
        int efe;
    } vec_t;
    vec_t tbl [4];

    int total = 0, bad = 0, cyc = 0;
    int nv0, nv2, nfe0, nfe2, last0, last2, sp;
    bit chk2;
    logic [31:0] q0 [$], q2 [$];
    logic [31:0] e0, e2;

    // word-level reference model
    bit m_prev, m_sync, m_hl;
    logic [15:0] m_hold;
    logic [31:0] cur_v;
    int cur_n, exp_fe;

    function automatic logic [15:0] align(input logic [31:0] v, input int n);
        return n >= 16 ? 16'(v >> (n - 16)) : 16'(v << (16 - n));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_sync = 0; m_hl = 0; m_hold = '0; cur_v = '0; cur_n = 0; exp_fe = 0;
        q0.delete(); q2.delete();
        nv0 = 0; nv2 = 0; nfe0 = 0; nfe2 = 0; last0 = -1; last2 = -1;
    endtask

    task automatic model_word(input bit ch, input logic [31:0] v, input int n);
        if (ch != m_prev) begin
            if (m_sync) begin
                if (cur_n != 16) exp_fe++;
                if (!m_prev) begin
                    m_hold = align(cur_v, cur_n);
                    m_hl = 1;
                end else begin
                    if (m_hl) begin
                        q0.push_back({m_hold, align(cur_v, cur_n)});
                        if (chk2) q2.push_back({m_hold, align(cur_v, cur_n)});
                    end
                    m_hl = 0;
                end
            end
            m_sync = 1;
            m_prev = ch;
        end
        cur_v = v;
        cur_n = n;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sv0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL valid0_unexpected: got strobe L=%h R=%h expected none", l0, r0);
            end else begin
                e0 = q0.pop_front();
                chk("pair0", {l0, r0}, e0);
            end
            if (sp > 0 && last0 >= 0) chk("spacing0", cyc - last0, sp);
            last0 = cyc;
            nv0++;
        end
        if (fe0) nfe0++;
    end

    always @(negedge clk) begin
        if (sv2) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL valid2_unexpected: got strobe L=%h R=%h expected none", l2, r2);
            end else begin
                e2 = q2.pop_front();
                chk("pair2", {l2, r2}, e2);
            end
            if (sp > 0 && last2 >= 0) chk("spacing2", cyc - last2, sp);
            last2 = cyc;
            nv2++;
        end
        if (fe2) nfe2++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input bit ch, input logic [31:0] v, input int n, input int half,
                             input int from, input int to);
        if (from == 0) model_word(ch, v, n);
        for (int i = from; i < to; i++) begin
            lrck = ch; bck = 1'b0; data = v[n-1-i];
            tick(half);
            bck = 1'b1;
            tick(half);
        end
    endtask

    task automatic send_frame(input logic [31:0] lv, input int ln, input logic [31:0] rv,
                              input int rn, input int half);
        send_word(1'b0, lv, ln, half, 0, ln);
        send_word(1'b1, rv, rn, half, 0, rn);
    endtask

    task automatic do_reset(input bit hold2);
        rst0 = 1'b1; rst2 = 1'b1; bck = 1'b0; lrck = 1'b0; data = 1'b0;
        tick(3);
        chk("reset_outs0", {sv0, fe0, l0, r0}, 64'd0);
        chk("reset_outs2", {sv2, fe2, l2, r2}, 64'd0);
        chk2 = !hold2;
        model_reset();
        rst0 = 1'b0; rst2 = hold2;
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{32'h8001, 16, 32'h7FFE, 16, 1, 16'h8001, 16'h7FFE, 0};
        tbl[1] = '{32'hA5A5, 16, 32'h5A5A, 16, 4, 16'hA5A5, 16'h5A5A, 0};
        tbl[2] = '{32'hABC, 12, 32'h1234, 16, 4, 16'hABC0, 16'h1234, 4};
        tbl[3] = '{32'hFEDCB, 20, 32'h12345, 20, 4, 16'hFEDC, 16'h1234, 8};
        chk2 = 0;
        sp = 0;
        model_reset();

        // fixed-pattern frames: 5 frames -> frame 1 lost to sync, frames 2..4 delivered
        for (int t = 0; t < 4; t++) begin
            do_reset(tbl[t].half < 2);
            sp = 2 * tbl[t].half * (tbl[t].ln + tbl[t].rn);
            repeat (5) send_frame(tbl[t].lv, tbl[t].ln, tbl[t].rv, tbl[t].rn, tbl[t].half);
            bck = 1'b0;
            tick(8);
            chk($sformatf("t%0d_left0", t), l0, tbl[t].el);
            chk($sformatf("t%0d_right0", t), r0, tbl[t].er);
            chk($sformatf("t%0d_nvalid0", t), nv0, 3);
            chk($sformatf("t%0d_nferr0", t), nfe0, tbl[t].efe);
            chk($sformatf("t%0d_pending0", t), q0.size(), 0);
            if (tbl[t].half >= 2) begin
                chk($sformatf("t%0d_left2", t), l2, tbl[t].el);
                chk($sformatf("t%0d_right2", t), r2, tbl[t].er);
                chk($sformatf("t%0d_nvalid2", t), nv2, 3);
                chk($sformatf("t%0d_nferr2", t), nfe2, tbl[t].efe);
                chk($sformatf("t%0d_pending2", t), q2.size(), 0);
            end
        end

        // reset asserted mid-right-word, released mid-left-word
        do_reset(0);
        sp = 0;
        send_frame(32'h1111, 16, 32'h2222, 16, 2);
        send_frame(32'h3333, 16, 32'h4444, 16, 2);
        send_frame(32'h5555, 16, 32'h6666, 16, 2);
        send_word(1'b0, 32'h7777, 16, 2, 0, 16);
        send_word(1'b1, 32'h8888, 16, 2, 0, 8);
        chk("t5_before0", {l0, r0}, 64'h5555_6666);
        rst0 = 1'b1; rst2 = 1'b1;
        #2;
        chk("t5_async0", {sv0, fe0, l0, r0}, 64'd0);
        chk("t5_async2", {sv2, fe2, l2, r2}, 64'd0);
        model_reset();
        tick(1);
        send_word(1'b0, 32'h9999, 16, 2, 0, 6);
        chk("t5_held0", {sv0, fe0, l0, r0}, 64'd0);
        chk("t5_held2", {sv2, fe2, l2, r2}, 64'd0);
        rst0 = 1'b0; rst2 = 1'b0;
        send_word(1'b0, 32'h9999, 16, 2, 6, 16);
        send_word(1'b1, 32'hA1A1, 16, 2, 0, 16);
        send_frame(32'hB2B2, 16, 32'hC3C3, 16, 2);
        send_word(1'b0, 32'hD4D4, 16, 2, 0, 16);
        bck = 1'b0;
        tick(8);
        chk("t5_nvalid0", nv0, 1);
        chk("t5_nvalid2", nv2, 1);
        chk("t5_pair0", {l0, r0}, 64'hB2B2_C3C3);
        chk("t5_pair2", {l2, r2}, 64'hB2B2_C3C3);
        chk("t5_nferr0", nfe0, exp_fe);

        // 100 random frames, strobe spacing and one-frame delay
        do_reset(0);
        sp = 128;
        for (int f = 0; f < 100; f++)
            send_frame(32'(16'($urandom)), 16, 32'(16'($urandom)), 16, 2);
        send_word(1'b0, 32'(16'($urandom)), 16, 2, 0, 16);
        bck = 1'b0;
        tick(8);
        chk("t6_nvalid0", nv0, 99);
        chk("t6_nvalid2", nv2, 99);
        chk("t6_nferr0", nfe0, exp_fe);
        chk("t6_nferr2", nfe2, exp_fe);
        chk("t6_pending0", q0.size(), 0);
        chk("t6_pending2", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
